// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for a 5-stage MIPS pipeline.
// It detects load-use and branch-operand hazards, freezes the pipeline while
// data memory is busy, and enters a sticky error state on a memory timeout.
// It also keeps saturating stall and flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_cnt_nxt;
  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic             w_load_use;
  logic             w_branch_hz;
  logic             w_hazard;
  logic             w_mem_stall;
  logic             w_timeout;

  // Register r is a live source of the instruction in ID (r0 never is).
  function automatic logic f_match(input logic [4:0] r,
                                   input logic [4:0] rs, input logic use_rs,
                                   input logic [4:0] rt, input logic use_rt);
    return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  assign w_load_use  = ex_mem_read &&
                       f_match(ex_write_reg, id_rs, id_uses_rs, id_rt, id_uses_rt);
  // Branches compare in ID, so any producer still in EX, or a load in MEM,
  // leaves the operand unavailable this cycle.
  assign w_branch_hz = id_branch &&
                       ((ex_reg_write &&
                         f_match(ex_write_reg, id_rs, id_uses_rs, id_rt, id_uses_rt)) ||
                        (mem_mem_read &&
                         f_match(mem_write_reg, id_rs, id_uses_rs, id_rt, id_uses_rt)));
  assign w_hazard    = w_load_use || w_branch_hz;
  assign w_mem_stall = mem_req && !mem_ready;
  assign w_timeout   = (r_wait_cnt + WC_W'(1)) == WC_W'(MEM_TIMEOUT);

  // Control outputs: prioritised decode of reset, error, memory stall, hazard, taken branch.
  always_comb begin
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_freeze    = 1'b1;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if ((r_state == S_ERROR) || w_mem_stall) begin
      pc_freeze    = 1'b1;
      ifid_freeze  = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (w_hazard) begin
      pc_freeze    = 1'b1;
      ifid_freeze  = 1'b1;
      idex_bubble  = 1'b1;
    end else if (id_branch && id_branch_taken) begin
      ifid_flush   = 1'b1;
    end else begin
      ifid_flush   = 1'b0;
    end
  end

  // Next state: track consecutive memory-stall cycles and trap on timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end else begin
          w_wait_cnt_nxt = WC_W'(0);
        end
      end
      S_MEM_WAIT: begin
        if (w_mem_stall && w_timeout) begin
          w_state_nxt    = S_ERROR;
        end else if (w_mem_stall) begin
          w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
        end else begin
          // A dropped request counts as completion.
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = WC_W'(0);
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = WC_W'(0);
      end
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= WC_W'(0);
      r_mem_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_mem_error <= (w_state_nxt == S_ERROR);
    end
  end

  // Saturating performance counters for freeze and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_freeze && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (ifid_flush && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign mem_error    = r_mem_error;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush scheduler for the 5-stage MIPS pipeline. Each cycle it drives the freeze, flush, hold and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use and branch-operand hazards and stalls the whole pipeline while data memory is busy. It enters a sticky error state on a memory timeout, and it keeps saturating stall/flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum consecutive memory-stall cycles before error (≥2)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5  source registers of instruction in IF/ID
- id_uses_rs, id_uses_rt  in  1  instruction reads rs / rt
- id_branch  in  1  IF/ID holds a branch/jump (compared in ID)
- id_branch_taken  in  1  ID comparison result; valid only when no hazard
- ex_mem_read  in  1  ID/EX instruction is a load
- ex_reg_write  in  1  ID/EX instruction writes a register
- ex_write_reg  in  5  ID/EX destination register
- mem_mem_read  in  1  EX/MEM instruction is a load
- mem_write_reg  in  5  EX/MEM destination register
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze  out  1  PC holds
- ifid_freeze  out  1  IF/ID holds
- ifid_flush  out  1  IF/ID loads a NOP
- idex_hold  out  1  ID/EX holds
- idex_bubble  out  1  ID/EX loads zeroed controls
- exmem_hold  out  1  EX/MEM holds
- memwb_bubble  out  1  MEM/WB loads zeroed WB controls
- mem_error  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  saturating count of pc_freeze cycles
- flush_count  out  CNT_W  saturating count of ifid_flush cycles

## Operation
- match(r) = r≠0 && ((id_uses_rs && r==id_rs) || (id_uses_rt && r==id_rt)).
- load_use = ex_mem_read && match(ex_write_reg).
- branch_hz = id_branch && ((ex_reg_write && match(ex_write_reg)) || (mem_mem_read && match(mem_write_reg))).
- mem_stall = mem_req && !mem_ready.
- Control outputs are combinational from state and inputs. Priority is rst > ERROR > mem_stall > (load_use||branch_hz) > id_branch_taken. Outputs not listed for a case are 0.
  - rst=1: pc_freeze, ifid_flush, idex_bubble, memwb_bubble = 1.
  - ERROR: pc_freeze, ifid_freeze, idex_hold, exmem_hold, memwb_bubble = 1.
  - mem_stall: pc_freeze, ifid_freeze, idex_hold, exmem_hold, memwb_bubble = 1.
  - hazard: pc_freeze, ifid_freeze, idex_bubble = 1.
  - id_branch && id_branch_taken: ifid_flush = 1.
- FSM states:
  - RUN: mem_stall → MEM_WAIT, with wait_cnt=1.
  - MEM_WAIT: mem_stall with wait_cnt+1==MEM_TIMEOUT → ERROR; otherwise mem_stall → wait_cnt++ and stay; !mem_stall → RUN.
  - RUN also → ERROR when mem_stall and MEM_TIMEOUT==1 is impossible (param ≥2).
  - ERROR: absorbing until rst; mem_error=1 in ERROR.
- wait_cnt width is clog2(MEM_TIMEOUT+1).
- Counters: stall_cycles += 1 on each non-rst cycle with pc_freeze=1. flush_count += 1 on each non-rst cycle with ifid_flush=1. Both saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Reset values: state RUN, wait_cnt 0, mem_error 0, stall_cycles 0, flush_count 0.
- Control outputs have zero latency (same cycle as inputs). Counters and mem_error update at the next rising edge.
- Memory stall lasting N cycles (mem_ready low for N cycles, then high):
  - N stall cycles.
  - Pipeline advances on the mem_ready cycle.
  - If N ≥ MEM_TIMEOUT: stalled cycles 1..MEM_TIMEOUT, ERROR from cycle MEM_TIMEOUT+1.
- mem_req deasserting while in MEM_WAIT is treated as completion: → RUN, no stall that cycle.
- A taken branch coincident with a hazard or mem_stall is not flushed. It is re-evaluated when released.
- Destination register 0 never causes a hazard.
- rst mid-MEM_WAIT or in ERROR: next cycle RUN, mem_error 0, counters 0.

## Test plan
- ex_mem_read=1, ex_write_reg=8, id_rs=8, id_uses_rs=1 for 1 cycle → pc_freeze=ifid_freeze=idex_bubble=1 that cycle; stall_cycles=1 next cycle. Same stimulus with register 0 → all controls 0.
- id_branch=1, id_branch_taken=1, no hazard → ifid_flush=1 for one cycle, flush_count=1. Same with ex_reg_write=1, ex_write_reg=id_rt=5, id_uses_rt=1 → stall, ifid_flush=0.
- Branch with EX/MEM load to id_rs=9 (mem_mem_read=1, mem_write_reg=9) → one-cycle stall; next cycle with no match and taken → ifid_flush=1.
- MEM_TIMEOUT=8, mem_req=1, mem_ready low 3 cycles then high → exmem_hold=memwb_bubble=1 for exactly 3 cycles, state RUN, stall_cycles=3, mem_error=0.
- MEM_TIMEOUT=4, mem_ready never high → stall cycles 1–4, mem_error=1 from cycle 5; remains 1 after mem_ready=1; rst for 1 cycle clears mem_error, counters and state.
- mem_stall + load_use + branch taken in the same cycle → only memory-stall controls; idex_bubble=0, ifid_flush=0. Preload stall_cycles near saturation → holds at 65535.
